// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter that shares one 8-bit FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_BURST_EN to let a grantee keep priority for up to MAX_BURST consecutive beats.
module fifo_wr_arb #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_DATA  = 16,
  parameter int ADDR_BITS = 5,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [ADDR_BITS:0]         fifo_count,
  input  logic                       fifo_ren,
  output logic                       fifo_wen,
  output logic [7:0]                 fifo_wdata,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS+1)'(MAX_DATA);

  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      winner;
  logic                 found;
  logic                 space;
  logic                 wen;
  logic [2*NUM_REQ-1:0] dbl_valid;
  logic [NUM_REQ-1:0]   rot_valid;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (int'(id) == NUM_REQ-1) ? '0 : id + ID_W'(1);
  endfunction

  // Rotate so that bit 0 is the producer at rr_ptr; lowest set bit wins.
  assign dbl_valid = {req_valid, req_valid} >> rr_ptr;
  assign rot_valid = dbl_valid[NUM_REQ-1:0];

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        found  = 1'b1;
        winner = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  // A read in the same cycle frees a slot, so writing at full is safe only then.
  assign space    = (fifo_count < FULL_CNT) || fifo_ren;
  assign wen      = found && space && rst_n;
  assign fifo_wen = wen;
  assign busy     = (|req_valid) && !wen && rst_n;

  always_comb begin
    req_ready  = '0;
    fifo_wdata = '0;
    grant_id   = '0;
    if (wen) begin
      req_ready[winner] = 1'b1;
      fifo_wdata        = req_data[8*int'(winner) +: 8];
      grant_id          = winner;
    end
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int BC_W = $clog2(MAX_BURST) + 1;

  logic [BC_W-1:0] burst_cnt;
  logic [BC_W-1:0] beats;

  // rr_ptr parks on the grantee during a burst; a different winner means it dropped valid.
  assign beats = (winner == rr_ptr) ? burst_cnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else if (wen) begin
      if (int'(beats) < MAX_BURST-1) begin
        rr_ptr    <= winner;
        burst_cnt <= beats + BC_W'(1);
      end else begin
        rr_ptr    <= next_id(winner);
        burst_cnt <= '0;
      end
    end else if (burst_cnt != '0) begin
      rr_ptr    <= next_id(rr_ptr);
      burst_cnt <= '0;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (wen) begin
      rr_ptr <= next_id(winner);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed vector table, reset corner cases and randomized
// traffic checked against a queue-based arbitration model.
module tb_fifo_wr_arb;
  localparam int N  = 4;
  localparam int MD = 16;
  localparam int AB = 5;
  localparam int MB = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [AB:0]    fifo_count;
  logic           fifo_ren;
  logic           fifo_wen;
  logic [7:0]     fifo_wdata;
  logic [IW-1:0]  grant_id;
  logic           busy;

  int checks = 0;
  int passed = 0;

  // Model state: where the next search starts and beats already given in a burst.
  int m_start = 0;
  int m_beats = 0;

  always #5 clk = ~clk;

  fifo_wr_arb #(.NUM_REQ(N), .MAX_DATA(MD), .ADDR_BITS(AB), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_count(fifo_count), .fifo_ren(fifo_ren),
    .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .grant_id(grant_id), .busy(busy)
  );

  typedef struct {
    logic [N-1:0] v;
    int           cnt;
    logic         ren;
    logic [N-1:0] rdy;
    logic         wen;
    logic [7:0]   wd;
    int           gid;
    logic         bsy;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Candidate list in priority order, first valid entry wins.
  task automatic model_eval(output int win, output logic w);
    int order[$];
    logic sp;
    sp = (int'(fifo_count) < MD) || fifo_ren;
    order = {};
    for (int k = 0; k < N; k++) order.push_back((m_start + k) % N);
    win = -1;
    foreach (order[j]) if (win < 0 && req_valid[order[j]]) win = order[j];
    w = (win >= 0) && sp;
  endtask

  task automatic model_update(input int win, input logic w);
`ifdef FIFO_ARB_BURST_EN
    int b;
    if (w) begin
      b = (m_beats > 0 && win == m_start) ? m_beats : 0;
      if (b + 1 < MB) begin
        m_start = win;
        m_beats = b + 1;
      end else begin
        m_start = (win + 1) % N;
        m_beats = 0;
      end
    end else if (m_beats > 0) begin
      m_start = (m_start + 1) % N;
      m_beats = 0;
    end
`else
    if (w) m_start = (win + 1) % N;
`endif
  endtask

  task automatic check_model(input string tag);
    int win;
    logic w;
    model_eval(win, w);
    check({tag, " wen"}, int'(fifo_wen), int'(w));
    check({tag, " ready"}, int'(req_ready), w ? (1 << win) : 0);
    check({tag, " wdata"}, int'(fifo_wdata), w ? int'(req_data[win*8 +: 8]) : 0);
    check({tag, " grant"}, int'(grant_id), w ? win : 0);
    check({tag, " busy"}, int'(busy), int'((req_valid != 0) && !w));
    model_update(win, w);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " ready"}, int'(req_ready), 0);
    check({tag, " wen"}, int'(fifo_wen), 0);
    check({tag, " wdata"}, int'(fifo_wdata), 0);
    check({tag, " grant"}, int'(grant_id), 0);
    check({tag, " busy"}, int'(busy), 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_zero("reset");
    m_start = 0;
    m_beats = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic [N-1:0] v, input int cnt, input logic ren);
    req_valid  = v;
    fifo_count = (AB+1)'(cnt);
    fifo_ren   = ren;
  endtask

  initial begin
    int win;
    logic w;
    drive('1, 0, 1'b0);
    req_data = 32'h44332211;
    rst_n    = 1'b0;
    apply_reset();

`ifdef FIFO_ARB_BURST_EN
    for (int i = 0; i < 9; i++) begin
      int g;
      g = (i / 4) % 2;
      tbl.push_back('{4'b0011, 0, 1'b0, 4'(1 << g), 1'b1, 8'((g + 1) * 8'h11), g, 1'b0});
    end
    tbl.push_back('{4'b0110, 0, 1'b0, 4'b0010, 1'b1, 8'h22, 1, 1'b0});
    tbl.push_back('{4'b0110, 0, 1'b0, 4'b0010, 1'b1, 8'h22, 1, 1'b0});
    tbl.push_back('{4'b0100, 0, 1'b0, 4'b0100, 1'b1, 8'h33, 2, 1'b0});
    tbl.push_back('{4'b0100, 16, 1'b0, 4'b0000, 1'b0, 8'h00, 0, 1'b1});
    tbl.push_back('{4'b0100, 0, 1'b0, 4'b0100, 1'b1, 8'h33, 2, 1'b0});
`else
    for (int i = 0; i < 5; i++)
      tbl.push_back('{4'b1111, 0, 1'b0, 4'(1 << (i % 4)), 1'b1, 8'(((i % 4) + 1) * 8'h11), i % 4, 1'b0});
    tbl.push_back('{4'b1111, 16, 1'b0, 4'b0000, 1'b0, 8'h00, 0, 1'b1});
    tbl.push_back('{4'b1111, 16, 1'b1, 4'b0010, 1'b1, 8'h22, 1, 1'b0});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{4'b0100, 0, 1'b0, 4'b0100, 1'b1, 8'h33, 2, 1'b0});
    tbl.push_back('{4'b0000, 0, 1'b0, 4'b0000, 1'b0, 8'h00, 0, 1'b0});
`endif

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tbl[i].v, tbl[i].cnt, tbl[i].ren);
      #2;
      check({tag, " ready"}, int'(req_ready), int'(tbl[i].rdy));
      check({tag, " wen"}, int'(fifo_wen), int'(tbl[i].wen));
      check({tag, " wdata"}, int'(fifo_wdata), int'(tbl[i].wd));
      check({tag, " grant"}, int'(grant_id), tbl[i].gid);
      check({tag, " busy"}, int'(busy), int'(tbl[i].bsy));
      model_eval(win, w);
      model_update(win, w);
      @(posedge clk);
      #1;
    end

    // Mid-stream reset with the pointer parked at producer 3.
    apply_reset();
    drive(4'b0001, 0, 1'b0);
    #2; check_model("pre0"); @(posedge clk); #1;
    drive(4'b0010, 0, 1'b0);
    #2; check_model("pre1"); @(posedge clk); #1;
    drive(4'b0100, 0, 1'b0);
    #2; check_model("pre2"); @(posedge clk); #1;
    drive(4'b1010, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    m_start = 0;
    m_beats = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #2;
    check("post-reset grant", int'(grant_id), 1);
    check_model("postrst");
    @(posedge clk);
    #1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(N'($urandom), ($urandom_range(0, 3) == 0) ? MD : int'($urandom_range(0, MD)),
            1'($urandom_range(0, 1)));
      req_data = $urandom;
      #2;
      check_model("rand");
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
